// File: rtl/stq_pkg.sv
`default_nettype none
// ============================================================================
// stq_pkg : shared constants, drain state type and one-hot helper
// Rev 1.0
// ============================================================================
package stq_pkg;

  localparam int STQ_BUF_COUNT = 64;
  localparam int STQ_IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HOLD  = 2'd3
  } drain_state_e;

  function automatic logic [STQ_BUF_COUNT-1:0] onehot_idx(input logic [STQ_IDX_W-1:0] idx);
    logic [STQ_BUF_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stq_drain_ostage.sv
`default_nettype none
// ============================================================================
// stq_drain_ostage : valid/ready output register for one drained store
// Rev 1.0
// ============================================================================
module stq_drain_ostage #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] idx_q;

  // A load always wins: the upstream only loads when the slot is empty or leaving.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      idx_q   <= idx_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule
`default_nettype wire

// File: rtl/stq_drain.sv
`default_nettype none
// ============================================================================
// stq_drain : in-order drain of committed store-queue entries to the L1 port
// Rev 1.0
// ============================================================================
module stq_drain
  import stq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BUF_COUNT = STQ_BUF_COUNT,
  parameter int IDX_W     = STQ_IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           commit_cnt_i,
  input  logic                 drain_hold_i,
  output logic [BUF_COUNT-1:0] rd_en_o,
  input  logic [WIDTH-1:0]     rd_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [IDX_W-1:0]     out_idx_o,
  output logic [BUF_COUNT-1:0] free_en_o,
  output logic [IDX_W:0]       cmt_pending_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  localparam int CW = IDX_W + 2;

  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W:0]       pend_q, pend_d;
  logic [BUF_COUNT-1:0] free_en_q;
  logic                 err_q, err_d;
  drain_state_e         state_q, state_d;

  logic                 can_issue;
  logic                 out_valid;
  logic [IDX_W-1:0]     out_idx;
  logic                 bad_cnt;
  logic [1:0]           cnt_eff;
  logic [CW-1:0]        sum;
  logic                 overflow;
  logic                 valid_d;

  assign can_issue = (pend_q != '0) && !drain_hold_i && (!out_valid || out_ready_i);
  assign rd_en_o   = can_issue ? onehot_idx(head_q) : '0;

  assign bad_cnt  = (commit_cnt_i == 2'd3);
  assign cnt_eff  = bad_cnt ? 2'd0 : commit_cnt_i;
  assign sum      = CW'(pend_q) + CW'(cnt_eff) - CW'(can_issue);
  assign overflow = (sum > CW'(BUF_COUNT));
  assign pend_d   = overflow ? (IDX_W+1)'(BUF_COUNT) : sum[IDX_W:0];
  assign err_d    = err_q | bad_cnt | overflow;
  // Head width is exactly log2(BUF_COUNT), so the increment wraps naturally.
  assign head_d   = can_issue ? head_q + 1'b1 : head_q;
  assign valid_d  = can_issue || (out_valid && !out_ready_i);

  // Status predicts the coming cycle from next-state counters and the current ready.
  always_comb begin
    state_d = RUN;
    if ((pend_d == '0) && !valid_d)           state_d = IDLE;
    else if (valid_d && !out_ready_i)         state_d = STALL;
    else if (drain_hold_i && (pend_d != '0))  state_d = HOLD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      pend_q    <= '0;
      free_en_q <= '0;
      err_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      head_q    <= head_d;
      pend_q    <= pend_d;
      free_en_q <= (out_valid && out_ready_i) ? onehot_idx(out_idx) : '0;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  stq_drain_ostage #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_ostage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (can_issue),
    .data_i  (rd_data_i),
    .idx_i   (head_q),
    .ready_i (out_ready_i),
    .valid_o (out_valid),
    .data_o  (out_data_o),
    .idx_o   (out_idx)
  );

  assign out_valid_o   = out_valid;
  assign out_idx_o     = out_idx;
  assign free_en_o     = free_en_q;
  assign cmt_pending_o = pend_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stq_drain.sv
`default_nettype none
// ============================================================================
// tb_stq_drain : directed self-checking bench for stq_drain
// Rev 1.0
// ============================================================================
module tb_stq_drain;
  import stq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  commit_cnt;
  logic        drain_hold;
  logic [63:0] rd_en;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic [63:0] free_en;
  logic [6:0]  cmt_pending;
  logic        err;
  logic [1:0]  state;

  logic [31:0] mem [64];
  int total = 0;
  int bad   = 0;

  stq_drain #(.WIDTH(32), .BUF_COUNT(64), .IDX_W(6)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .commit_cnt_i  (commit_cnt),
    .drain_hold_i  (drain_hold),
    .rd_en_o       (rd_en),
    .rd_data_i     (rd_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_idx_o     (out_idx),
    .free_en_o     (free_en),
    .cmt_pending_o (cmt_pending),
    .err_o         (err),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: combinational read of the selected entry.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 64; i++) if (rd_en[i]) rd_data = mem[i];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; commit_cnt = 2'd0; drain_hold = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; commit_cnt = 2'd1; drain_hold = 1'b0; out_ready = 1'b1;
    step(); step();
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0)   begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (out_idx !== 6'd0)     begin bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    total++; if (free_en !== 64'h0)    begin bad++; $display("FAIL reset_free: got %h want 0", free_en); end
    total++; if (cmt_pending !== 7'd0) begin bad++; $display("FAIL reset_pend: got %0d want 0", cmt_pending); end
    total++; if (err !== 1'b0)         begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (rd_en !== 64'h0)      begin bad++; $display("FAIL reset_rden: got %h want 0", rd_en); end
    total++; if (state !== IDLE)       begin bad++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    commit_cnt = 2'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    out_ready = 1'b1; commit_cnt = 2'd1;
    step();
    commit_cnt = 2'd0;
    total++; if (rd_en !== 64'h1)      begin bad++; $display("FAIL basic_rden: got %h want 1", rd_en); end
    total++; if (cmt_pending !== 7'd1) begin bad++; $display("FAIL basic_pend1: got %0d want 1", cmt_pending); end
    step();
    total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data: got %h want deadbeef", out_data); end
    total++; if (out_idx !== 6'd0)     begin bad++; $display("FAIL basic_idx: got %0d want 0", out_idx); end
    total++; if (rd_en !== 64'h0)      begin bad++; $display("FAIL basic_rden_idle: got %h want 0", rd_en); end
    step();
    total++; if (free_en !== 64'h1)    begin bad++; $display("FAIL basic_free: got %h want 1", free_en); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
    total++; if (cmt_pending !== 7'd0) begin bad++; $display("FAIL basic_pend0: got %0d want 0", cmt_pending); end
    step();
    total++; if (free_en !== 64'h0)    begin bad++; $display("FAIL basic_free_pulse: got %h want 0", free_en); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0; commit_cnt = 2'd1;
    step(); step(); step();
    commit_cnt = 2'd0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_idx !== 6'd0 || out_valid !== 1'b1 || rd_en !== 64'h0) begin
        bad++; $display("FAIL bp_stall%0d: got idx=%0d valid=%b rden=%h want 0/1/0", i, out_idx, out_valid, rd_en);
      end
      if (i < 3) step();
    end
    total++; if (cmt_pending !== 7'd2) begin bad++; $display("FAIL bp_pend: got %0d want 2", cmt_pending); end
    out_ready = 1'b1;
    #1;
    total++; if (rd_en !== 64'h2) begin bad++; $display("FAIL bp_rden: got %h want 2", rd_en); end
    step();
    total++; if (out_idx !== 6'd1 || free_en !== 64'h1) begin bad++; $display("FAIL bp_d1: got idx=%0d free=%h want 1/1", out_idx, free_en); end
    step();
    total++; if (out_idx !== 6'd2 || free_en !== 64'h2) begin bad++; $display("FAIL bp_d2: got idx=%0d free=%h want 2/2", out_idx, free_en); end
    step();
    total++; if (out_valid !== 1'b0 || free_en !== 64'h4) begin bad++; $display("FAIL bp_d3: got valid=%b free=%h want 0/4", out_valid, free_en); end
  endtask

  task automatic test_wrap;
    logic [5:0]  idxs [4];
    logic [63:0] frees [4];
    logic [31:0] data63;
    int ni, nf;
    bit idle;
    do_reset();
    out_ready = 1'b1; commit_cnt = 2'd2;
    for (int i = 0; i < 31; i++) step();
    commit_cnt = 2'd0;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      step();
      idle = (cmt_pending == 7'd0) && !out_valid && (free_en == 64'h0);
    end
    total++; if (!idle) begin bad++; $display("FAIL wrap_predrain: got busy want idle"); end
    ni = 0; nf = 0; data63 = '0;
    for (int i = 0; i < 14; i++) begin
      commit_cnt = (i < 2) ? 2'd2 : 2'd0;
      step();
      if (out_valid && ni < 4) begin
        idxs[ni] = out_idx;
        if (out_idx == 6'd63) data63 = out_data;
        ni++;
      end
      if (free_en != 64'h0 && nf < 4) begin frees[nf] = free_en; nf++; end
    end
    total++; if (ni !== 4 || nf !== 4) begin bad++; $display("FAIL wrap_count: got %0d/%0d want 4/4", ni, nf); end
    else begin
      total++; if (idxs[0] !== 6'd62 || idxs[1] !== 6'd63 || idxs[2] !== 6'd0 || idxs[3] !== 6'd1) begin
        bad++; $display("FAIL wrap_idx: got %0d %0d %0d %0d want 62 63 0 1", idxs[0], idxs[1], idxs[2], idxs[3]);
      end
      total++; if (frees[0] !== (64'd1 << 62) || frees[1] !== (64'd1 << 63) || frees[2] !== 64'h1 || frees[3] !== 64'h2) begin
        bad++; $display("FAIL wrap_free: got %h %h %h %h want bits 62 63 0 1", frees[0], frees[1], frees[2], frees[3]);
      end
      total++; if (data63 !== 32'hA000_003F) begin bad++; $display("FAIL wrap_data: got %h want a000003f", data63); end
    end
  endtask

  task automatic test_simul;
    do_reset();
    drain_hold = 1'b1; out_ready = 1'b0;
    commit_cnt = 2'd2; step();
    commit_cnt = 2'd2; step();
    commit_cnt = 2'd1; step();
    total++; if (cmt_pending !== 7'd5 || rd_en !== 64'h0) begin bad++; $display("FAIL simul_pend5: got %0d rden=%h want 5/0", cmt_pending, rd_en); end
    total++; if (state !== HOLD) begin bad++; $display("FAIL simul_state: got %0d want %0d", state, HOLD); end
    drain_hold = 1'b0; out_ready = 1'b1; commit_cnt = 2'd2;
    #1;
    total++; if (rd_en !== 64'h1) begin bad++; $display("FAIL simul_rden: got %h want 1", rd_en); end
    step();
    commit_cnt = 2'd0;
    total++; if (cmt_pending !== 7'd6) begin bad++; $display("FAIL simul_pend6: got %0d want 6", cmt_pending); end
    total++; if (out_valid !== 1'b1 || out_idx !== 6'd0) begin bad++; $display("FAIL simul_out: got valid=%b idx=%0d want 1/0", out_valid, out_idx); end
  endtask

  task automatic test_errors;
    do_reset();
    commit_cnt = 2'd3; step();
    commit_cnt = 2'd0;
    total++; if (err !== 1'b1 || cmt_pending !== 7'd0) begin bad++; $display("FAIL err_cnt3: got err=%b pend=%0d want 1/0", err, cmt_pending); end
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
    drain_hold = 1'b1; out_ready = 1'b0; commit_cnt = 2'd2;
    for (int i = 0; i < 32; i++) step();
    total++; if (cmt_pending !== 7'd64 || err !== 1'b0) begin bad++; $display("FAIL err_full: got pend=%0d err=%b want 64/0", cmt_pending, err); end
    commit_cnt = 2'd1; step();
    commit_cnt = 2'd0;
    total++; if (cmt_pending !== 7'd64 || err !== 1'b1) begin bad++; $display("FAIL err_sat: got pend=%0d err=%b want 64/1", cmt_pending, err); end
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b1; commit_cnt = 2'd2;
    step(); step();
    commit_cnt = 2'd0;
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 6'd1 || free_en !== 64'h1 || rd_en !== 64'h4) begin
      bad++; $display("FAIL ar_pre: got valid=%b idx=%0d free=%h rden=%h want 1/1/1/4", out_valid, out_idx, free_en, rd_en);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || free_en !== 64'h0 || rd_en !== 64'h0 || cmt_pending !== 7'd0) begin
      bad++; $display("FAIL ar_async: got valid=%b free=%h rden=%h pend=%0d want all 0", out_valid, free_en, rd_en, cmt_pending);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    commit_cnt = 2'd1; step();
    commit_cnt = 2'd0;
    total++; if (rd_en !== 64'h1) begin bad++; $display("FAIL ar_head_rden: got %h want 1", rd_en); end
    step();
    total++; if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ar_head: got valid=%b idx=%0d data=%h want 1/0/deadbeef", out_valid, out_idx, out_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'hDEADBEEF;
    rst_n = 1'b0; commit_cnt = 2'd0; drain_hold = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_simul();
    test_errors();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
